shift_deserializer: RTL and testbench
=====================================

// Module: shift_deserializer
// PURPOSE
//  Receive end of the serial shifter link: collects a bit stream (MSB- or LSB-first,
//  per dir) into a WIDTH-bit word and presents it on a valid/ready output port.
//  Sits between the serial shifter output and the ALU operand registers.
//  Supports gapped input (sin_valid), frame abort/restart and overrun detection.
// PARAMETERS
//  WIDTH  4  data bits per frame (>=2); counter width = $clog2(WIDTH+1)
// PORTS
//  clk        in   1      rising-edge clock; single clock domain
//  rst        in   1      synchronous, active-high reset
//  start      in   1      frame-start pulse; sin ignored in the start cycle
//  dir        in   1      0 = MSB-first, 1 = LSB-first; sampled only when start=1
//  sin        in   1      serial data bit
//  sin_valid  in   1      sin carries a valid bit this cycle
//  out_ready  in   1      consumer accepts y this cycle
//  y          out  WIDTH  assembled word
//  out_valid  out  1      y holds an unconsumed word
//  busy       out  1      frame in progress (state != IDLE)
//  overrun    out  1      sticky: unconsumed word overwritten
//  par_err    out  1      parity mismatch for the word in y (macro only, else 0)
// BEHAVIOUR
//  - Reset: y=0, out_valid=0, busy=0, overrun=0, par_err=0, count=0, state=IDLE.
//  - States: IDLE -> RECV on start. RECV -> IDLE after WIDTH-th valid bit
//    (-> PAR instead when PARITY_CHECK_EN). PAR -> IDLE on next valid bit.
//  - start in any state (incl. RECV/PAR): count=0, re-latch dir, enter RECV;
//    partial frame discarded, no out_valid, no overrun.
//  - RECV, sin_valid=1: dir=0 sr<={sr[W-2:0],sin}; dir=1 sr<={sin,sr[W-1:1]};
//    count++. sin_valid=0: sr and count hold (gaps allowed, unbounded).
//  - sin_valid ignored in IDLE.
//  - Completion (last data bit, or parity bit with macro): next cycle y=word,
//    out_valid=1, busy=0. Latency: 1 clk from last accepted bit to out_valid.
//  - out_valid stays 1, y stable, until out_valid&&out_ready; clears next cycle.
//  - Completion in same cycle as out_valid&&out_ready: y loads new word,
//    out_valid stays 1, no overrun.
//  - Completion while out_valid=1 and out_ready=0: y overwritten, out_valid
//    stays 1, overrun<=1; overrun only cleared by rst.
//  - out_ready while out_valid=0: no effect.
//  - rst mid-frame: all state to reset values, partial frame lost.
// CONFIGURATION
//  PARITY_CHECK_EN defined: frame = WIDTH data bits + 1 even-parity bit; PAR
//    state consumes it; par_err = ^data ^ parity_bit, loaded with y, held with y.
//  PARITY_CHECK_EN undefined: frame = WIDTH bits, no PAR state, par_err tied 0.
// TESTING (WIDTH=4)
//  1. dir=0, start, sin 1,0,1,0 contiguous -> y=4'b1010, out_valid 1 clk after 4th bit
//  2. dir=1, start, sin 1,0,1,1 -> y=4'b1101; busy=1 from start+1 until completion
//  3. Test 1 with 2-cycle sin_valid=0 gaps between bits -> y=4'b1010, same latency
//     after last bit; busy held through gaps
//  4. out_ready=0, two frames 1010 then 0011 -> y=0011, overrun=1;
//     out_ready=1 -> out_valid=0 next clk; rst -> all outputs 0
//  5. start, bits 1,1, start again, bits 0,1,1,0 (dir=0) -> single out_valid,
//     y=4'b0110, overrun=0
//  6. PARITY_CHECK_EN: data 1010 + parity 1 -> par_err=1; data 1010 + parity 0
//     -> par_err=0; out_valid only after 5th bit

Source files
------------

// File: rtl/shift_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_deserializer
//  Description : Receive end of the serial shifter link. Collects a gapped
//                serial bit stream (MSB- or LSB-first) into a WIDTH-bit word
//                and presents it on a valid/ready output port with sticky
//                overrun detection. Optional even-parity bit per frame when
//                the PARITY_CHECK_EN macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             par_err
);

    localparam int             c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_recv = 2'd1;
`ifdef PARITY_CHECK_EN
    localparam logic [1:0] c_st_par  = 2'd2;
`endif

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_count;
    logic               r_dir;
    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   r_y;
    logic               r_out_valid;
    logic               r_overrun;

    logic               w_accept;
    logic               w_last;
    logic               w_complete;
    logic [WIDTH-1:0]   w_sr_next;
    logic [WIDTH-1:0]   w_word;

`ifdef PARITY_CHECK_EN
    logic               r_par_err;
    logic               w_par_bit;
    logic               w_perr;
`endif

    // Next shift-register value, bit acceptance and frame completion decode.
    // A start pulse always wins: the bit presented with it is ignored.
    always_comb begin
        w_sr_next = r_dir ? {sin, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], sin};
        w_accept  = (r_state == c_st_recv) && sin_valid && !start;
        w_last    = w_accept && (r_count == c_last_idx);
`ifdef PARITY_CHECK_EN
        w_par_bit  = (r_state == c_st_par) && sin_valid && !start;
        w_complete = w_par_bit;
        w_word     = r_sr;
        w_perr     = (^r_sr) ^ sin;
`else
        w_complete = w_last;
        w_word     = w_sr_next;
`endif
    end

    // Frame FSM: bit counter, direction latch and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_sr    <= '0;
        end else if (start) begin
            // Restart from any state; any partial frame is dropped silently.
            r_state <= c_st_recv;
            r_count <= '0;
            r_dir   <= dir;
            r_sr    <= '0;
        end else begin
            case (r_state)
                c_st_recv: begin
                    if (w_accept) begin
                        r_sr <= w_sr_next;
                        if (w_last) begin
                            r_count <= '0;
`ifdef PARITY_CHECK_EN
                            r_state <= c_st_par;
`else
                            r_state <= c_st_idle;
`endif
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
`ifdef PARITY_CHECK_EN
                c_st_par: begin
                    if (w_par_bit) begin
                        r_state <= c_st_idle;
                    end
                end
`endif
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Output port: load word on completion, clear on handshake, flag overrun
    // when an unconsumed word is replaced.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_par_err   <= 1'b0;
`endif
        end else if (w_complete) begin
            r_y         <= w_word;
            r_out_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
            r_par_err   <= w_perr;
`endif
            if (r_out_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign y         = r_y;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != c_st_idle);
    assign overrun   = r_overrun;
`ifdef PARITY_CHECK_EN
    assign par_err   = r_par_err;
`else
    assign par_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_deserializer
//  Description : Self-checking bench for shift_deserializer (WIDTH=4):
//                vector table, directed multi-cycle sequences and a random
//                phase against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_deserializer;

    localparam int W = 4;
`ifdef PARITY_CHECK_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         dir = 1'b0;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] y;
    logic         out_valid;
    logic         busy;
    logic         overrun;
    logic         par_err;

    shift_deserializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .sin       (sin),
        .sin_valid (sin_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a frame is a list of received bits; the word is built
    // arithmetically once the list reaches the frame length.
    bit           m_busy  = 1'b0;
    bit           m_dir   = 1'b0;
    bit           m_valid = 1'b0;
    bit           m_ovr   = 1'b0;
    bit           m_perr  = 1'b0;
    logic [W-1:0] m_y     = '0;
    bit           q[$];

    task automatic model_step();
        bit           done;
        int           acc;
        bit           pe;
        done = 1'b0;
        acc  = 0;
        pe   = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
            m_y = '0; m_dir = 1'b0;
            q.delete();
            return;
        end
        if (start) begin
            m_busy = 1'b1;
            m_dir  = dir;
            q.delete();
        end else if (m_busy && sin_valid) begin
            q.push_back(sin);
            if (q.size() == FRAME) begin
                for (int i = 0; i < W; i++)
                    acc += int'(q[i]) * (m_dir ? (2 ** i) : (2 ** (W - 1 - i)));
                for (int i = 0; i < FRAME; i++) pe ^= q[i];
                if (FRAME == W) pe = 1'b0;
                done   = 1'b1;
                m_busy = 1'b0;
                q.delete();
            end
        end
        if (done) begin
            if (m_valid && !out_ready) m_ovr = 1'b1;
            m_y     = W'(acc);
            m_valid = 1'b1;
            m_perr  = pe;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: apply inputs, advance model, then compare after the edge.
    task automatic cyc(input bit st, input bit d, input bit s, input bit sv, input bit rdy);
        start = st; dir = d; sin = s; sin_valid = sv; out_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        chk("model.y", y, m_y);
        chk("model.out_valid", out_valid, m_valid);
        chk("model.busy", busy, m_busy);
        chk("model.overrun", overrun, m_ovr);
        chk("model.par_err", par_err, m_perr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("rst.y", y, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.overrun", overrun, 0);
        chk("rst.par_err", par_err, 0);
    endtask

    task automatic send_frame(input bit d, input logic [W-1:0] bits_msb_first, input bit rdy);
        logic [W-1:0] b;
        b = bits_msb_first;
        cyc(1, d, 0, 0, rdy);
        for (int i = W - 1; i >= 0; i--) cyc(0, 0, b[i], 1, rdy);
    endtask

    typedef struct {
        bit [4:0]     in;   // start, dir, sin, sin_valid, out_ready
        logic [W-1:0] ey;
        bit [2:0]     eo;   // out_valid, busy, overrun
    } vec_t;

    function automatic vec_t row(input bit [4:0] in, input logic [W-1:0] ey, input bit [2:0] eo);
        vec_t v;
        v.in = in; v.ey = ey; v.eo = eo;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        do_reset();

`ifndef PARITY_CHECK_EN
        // dir=0, bits 1,0,1,0 -> 1010; then dir=1, bits 1,0,1,1 -> 1101
        tbl[0]  = row(5'b10000, 4'b0000, 3'b010);
        tbl[1]  = row(5'b00110, 4'b0000, 3'b010);
        tbl[2]  = row(5'b00010, 4'b0000, 3'b010);
        tbl[3]  = row(5'b00110, 4'b0000, 3'b010);
        tbl[4]  = row(5'b00010, 4'b1010, 3'b100);
        tbl[5]  = row(5'b00001, 4'b1010, 3'b000);
        tbl[6]  = row(5'b11000, 4'b1010, 3'b010);
        tbl[7]  = row(5'b00110, 4'b1010, 3'b010);
        tbl[8]  = row(5'b00010, 4'b1010, 3'b010);
        tbl[9]  = row(5'b00110, 4'b1010, 3'b010);
        tbl[10] = row(5'b00110, 4'b1101, 3'b100);
        tbl[11] = row(5'b00001, 4'b1101, 3'b000);
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
            chk($sformatf("tbl%0d.y", i), y, tbl[i].ey);
            chk($sformatf("tbl%0d.out_valid", i), out_valid, tbl[i].eo[2]);
            chk($sformatf("tbl%0d.busy", i), busy, tbl[i].eo[1]);
            chk($sformatf("tbl%0d.overrun", i), overrun, tbl[i].eo[0]);
        end

        // Gapped stream: two idle cycles between bits, busy held throughout
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < W; k++) begin
            cyc(0, 0, (k % 2 == 0), 1, 0);
            if (k < W - 1) begin
                chk("gap.out_valid_early", out_valid, 0);
                for (int g = 0; g < 2; g++) begin
                    cyc(0, 1, bit'($urandom_range(0, 1)), 0, 0);
                    chk("gap.busy", busy, 1);
                end
            end
        end
        chk("gap.y", y, 4'b1010);
        chk("gap.out_valid", out_valid, 1);
        chk("gap.busy_done", busy, 0);
        cyc(0, 0, 0, 0, 1);

        // Overrun: two frames without consumption
        send_frame(0, 4'b1010, 0);
        chk("ovr.first_overrun", overrun, 0);
        send_frame(0, 4'b0011, 0);
        chk("ovr.y", y, 4'b0011);
        chk("ovr.overrun", overrun, 1);
        chk("ovr.out_valid", out_valid, 1);
        cyc(0, 0, 0, 0, 1);
        chk("ovr.consumed", out_valid, 0);
        chk("ovr.sticky", overrun, 1);
        do_reset();

        // Restart mid-frame: partial 1,1 discarded
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0);
        chk("restart.no_valid", out_valid, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        chk("restart.no_valid_late", out_valid, 0);
        cyc(0, 0, 0, 1, 0);
        chk("restart.y", y, 4'b0110);
        chk("restart.out_valid", out_valid, 1);
        chk("restart.overrun", overrun, 0);
        cyc(0, 0, 0, 0, 1);
`else
        // Parity frames: 1010 + parity 1 (error), then 1010 + parity 0
        for (int f = 0; f < 2; f++) begin
            send_frame(0, 4'b1010, 0);
            chk("par.no_valid_after_data", out_valid, 0);
            chk("par.busy_in_parity", busy, 1);
            cyc(0, 0, (f == 0), 1, 0);
            chk("par.y", y, 4'b1010);
            chk("par.out_valid", out_valid, 1);
            chk("par.par_err", par_err, (f == 0));
            cyc(0, 0, 0, 0, 1);
        end
`endif

        // Random phase against the reference model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            cyc($urandom_range(0, 19) == 0, bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
                bit'($urandom_range(0, 1)));
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
